// File: rtl/display_pkg.sv
// ============================================================================
// Module  : display_pkg
// Brief   : Shared scan-state type and hex-to-7-segment pattern table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

  typedef enum logic [1:0] {
    LS_ON   = 2'd0,
    BLANK_A = 2'd1,
    MS_ON   = 2'd2,
    BLANK_B = 2'd3
  } state_e;

  // Indexed by hex value; bit6..bit0 = g..a, active-high.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module  : seg7_decode
// Brief   : Combinational full-hex to 7-segment decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

`default_nettype wire

// File: rtl/display_scan.sv
// ============================================================================
// Module  : display_scan
// Brief   : Two-digit multiplexed 7-segment scanner with dead-time between
//           digit slots. Define LEADING_ZERO_BLANK_EN to blank a zero MS digit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan
  import display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 1200,
  parameter int BLANK_CYCLES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] nibble_ms,
  input  logic [3:0] nibble_ls,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       frame_start
);

  localparam int SLOT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W    = $clog2(SLOT_MAX);

  localparam logic [CNT_W-1:0] C_DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow_ms_q, shadow_ms_d;
  logic [3:0]       shadow_ls_q, shadow_ls_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    shadow_ms_d = shadow_ms_q;
    shadow_ls_d = shadow_ls_q;
    if (!en) begin
      // Park in the pre-frame blank so re-enable serves a full dead time.
      state_d = BLANK_B;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LS_ON: if (cnt_q == C_DIGIT_LAST) begin
          state_d = BLANK_A;
          cnt_d   = '0;
        end
        BLANK_A: if (cnt_q == C_BLANK_LAST) begin
          state_d = MS_ON;
          cnt_d   = '0;
        end
        MS_ON: if (cnt_q == C_DIGIT_LAST) begin
          state_d = BLANK_B;
          cnt_d   = '0;
        end
        BLANK_B: if (cnt_q == C_BLANK_LAST) begin
          state_d     = LS_ON;
          cnt_d       = '0;
          shadow_ms_d = nibble_ms;
          shadow_ls_d = nibble_ls;
        end
        default: begin
          state_d = BLANK_B;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BLANK_B;
      cnt_q       <= '0;
      shadow_ms_q <= 4'h0;
      shadow_ls_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_ms_q <= shadow_ms_d;
      shadow_ls_q <= shadow_ls_d;
    end
  end

  logic       w_ls_on;
  logic       w_ms_on;
  logic       w_lz_blank;
  logic [3:0] w_hex;
  logic [6:0] w_dec_seg;

  assign w_ls_on = (state_q == LS_ON);
  assign w_ms_on = (state_q == MS_ON);
  assign w_hex   = w_ms_on ? shadow_ms_q : shadow_ls_q;

  seg7_decode u_seg7_decode (
    .hex_i (w_hex),
    .seg_o (w_dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz_blank = w_ms_on && (shadow_ms_q == 4'h0);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign seg         = ((w_ls_on || w_ms_on) && !w_lz_blank) ? w_dec_seg : 7'h00;
  assign dig_sel     = {w_ms_on, w_ls_on};
  assign frame_start = w_ls_on && (cnt_q == '0);

endmodule

`default_nettype wire
